// File: rtl/mlp_adapter_pkg.sv
// Shared types and widths for the MLP stream adapter.
// Latency: n/a (declarations only).
// Backpressure: n/a. Widths are sized from the default frame and timeout sizes; grow these if a larger instance is needed.
package mlp_adapter_pkg;

  localparam int DEF_INPUT_SIZE     = 16;
  localparam int DEF_OUTPUT_SIZE    = 5;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  localparam int IDX_W  = $clog2(DEF_INPUT_SIZE);
  localparam int OIDX_W = $clog2(DEF_OUTPUT_SIZE + 1);
  localparam int TO_W   = $clog2(DEF_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    FILL   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    DLY    = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  // Counter width that stays legal for counts of 0 or 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_argmax.sv
// Index of the largest signed word in a packed vector; ties go to the lowest index.
// Latency: combinational.
// Backpressure: none.
module mlp_argmax #(
  parameter int WIDTH = 16,
  parameter int N     = 5,
  parameter int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*WIDTH-1:0] data_i,
  output logic [IW-1:0]      idx_o
);

  logic signed [WIDTH-1:0] best_v;
  logic signed [WIDTH-1:0] cur_v;

  // Linear scan; strict greater-than keeps the earliest of equal maxima.
  always_comb begin
    idx_o  = '0;
    best_v = data_i[WIDTH-1:0];
    cur_v  = '0;
    for (int i = 1; i < N; i++) begin
      cur_v = data_i[i*WIDTH +: WIDTH];
      if (cur_v > best_v) begin
        best_v = cur_v;
        idx_o  = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mlp_stream_adapter.sv
// Word-serial front/back end for the MLP: fills a feature vector, launches the net, serialises its result.
// Latency: last input beat -> launch pulse +1 cycle; output_ready edge -> first m_valid +1+CAPTURE_DELAY cycles.
// Backpressure: s_ready only in FILL; DRAIN holds m_data/m_last while m_ready is low. Macro MLP_ADAPTER_ARGMAX_EN appends an argmax word.
module mlp_stream_adapter
  import mlp_adapter_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int NFRAC          = 10,
  parameter int INPUT_SIZE     = DEF_INPUT_SIZE,
  parameter int OUTPUT_SIZE    = DEF_OUTPUT_SIZE,
  parameter int CAPTURE_DELAY  = 1,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WIDTH-1:0]            s_data,
  input  logic                        s_last,
  output logic                        nn_input_ready,
  output logic [WIDTH*INPUT_SIZE-1:0] nn_input_data,
  input  logic                        nn_output_ready,
  input  logic [WIDTH*OUTPUT_SIZE-1:0] nn_output_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WIDTH-1:0]            m_data,
  output logic                        m_last,
  output logic                        busy,
  output logic                        err_frame,
  output logic                        err_timeout
);

`ifdef MLP_ADAPTER_ARGMAX_EN
  localparam int NWORDS = OUTPUT_SIZE + 1;
`else
  localparam int NWORDS = OUTPUT_SIZE;
`endif
  localparam int DLY_W = cnt_w(CAPTURE_DELAY);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((CAPTURE_DELAY > 0) ? CAPTURE_DELAY - 1 : 0);

  state_t                               state_q, state_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [OIDX_W-1:0]                    oidx_q, oidx_d;
  logic [TO_W-1:0]                      to_q, to_d;
  logic [DLY_W-1:0]                     dly_q, dly_d;
  logic                                 prev_q;
  logic [INPUT_SIZE-1:0][WIDTH-1:0]     ibuf_q;
  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]    obuf_q;
  logic                                 ibuf_we;
  logic                                 cap;

  // State, counters and buffers; ready level is sampled every cycle for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      oidx_q  <= '0;
      to_q    <= '0;
      dly_q   <= '0;
      prev_q  <= 1'b0;
      ibuf_q  <= '0;
      obuf_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oidx_q  <= oidx_d;
      to_q    <= to_d;
      dly_q   <= dly_d;
      prev_q  <= nn_output_ready;
      if (ibuf_we) ibuf_q[idx_q] <= s_data;
      if (cap)     obuf_q        <= nn_output_data;
    end
  end

  // Next-state and pulse decode for the fill/launch/wait/drain sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    oidx_d      = oidx_q;
    to_d        = to_q;
    dly_d       = dly_q;
    ibuf_we     = 1'b0;
    cap         = 1'b0;
    err_frame   = 1'b0;
    err_timeout = 1'b0;
    case (state_q)
      FILL: begin
        if (s_valid) begin
          ibuf_we = 1'b1;
          if (idx_q == IDX_W'(INPUT_SIZE - 1)) begin
            // A full frame launches even if its framing is wrong.
            idx_d     = '0;
            state_d   = LAUNCH;
            err_frame = !s_last;
          end else if (s_last) begin
            // Short frame is dropped; stale buffer words get overwritten by the next frame.
            idx_d     = '0;
            err_frame = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LAUNCH: begin
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Only a fresh rising edge counts; a level left high from before is ignored.
        if (nn_output_ready && !prev_q) begin
          if (CAPTURE_DELAY == 0) begin
            cap     = 1'b1;
            oidx_d  = '0;
            state_d = DRAIN;
          end else begin
            dly_d   = '0;
            state_d = DLY;
          end
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout = 1'b1;
          state_d     = FILL;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      DLY: begin
        if (dly_q == DLY_LAST) begin
          cap     = 1'b1;
          oidx_d  = '0;
          state_d = DRAIN;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (oidx_q == OIDX_W'(NWORDS - 1)) begin
            oidx_d  = '0;
            state_d = FILL;
          end else begin
            oidx_d = oidx_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

`ifdef MLP_ADAPTER_ARGMAX_EN
  logic [OIDX_W-1:0] amax_w;
  logic [OIDX_W-1:0] amax_q;

  mlp_argmax #(
    .WIDTH (WIDTH),
    .N     (OUTPUT_SIZE),
    .IW    (OIDX_W)
  ) u_argmax (
    .data_i (nn_output_data),
    .idx_o  (amax_w)
  );

  // Argmax is registered alongside the result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) amax_q <= '0;
    else if (cap) amax_q <= amax_w;
  end
`endif

  // Outbound word select; all sources are registers so the word is stable under stall.
  always_comb begin
    m_data = '0;
    for (int i = 0; i < OUTPUT_SIZE; i++) begin
      if (oidx_q == OIDX_W'(i)) m_data = obuf_q[i];
    end
`ifdef MLP_ADAPTER_ARGMAX_EN
    if (oidx_q == OIDX_W'(OUTPUT_SIZE)) m_data = WIDTH'(amax_q);
`endif
  end

  assign s_ready        = (state_q == FILL);
  assign busy           = (state_q != FILL);
  assign nn_input_ready = (state_q == LAUNCH);
  assign nn_input_data  = ibuf_q;
  assign m_valid        = (state_q == DRAIN);
  assign m_last         = (state_q == DRAIN) && (oidx_q == OIDX_W'(NWORDS - 1));

endmodule

// File: tb/tb_mlp_stream_adapter.sv
// Directed bench for mlp_stream_adapter (TIMEOUT_CYCLES=8, CAPTURE_DELAY=1).
// Inputs are driven and outputs sampled on the falling clock edge.
// Optional argmax checks follow MLP_ADAPTER_ARGMAX_EN.
module tb_mlp_stream_adapter;

`ifdef MLP_ADAPTER_ARGMAX_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [15:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         nn_input_ready;
  logic [255:0] nn_input_data;
  logic         nn_output_ready = 1'b0;
  logic [79:0]  nn_output_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [15:0]  m_data;
  logic         m_last;
  logic         busy;
  logic         err_frame;
  logic         err_timeout;

  int vecs = 0;
  int errs = 0;
  int launches = 0;

  mlp_stream_adapter #(
    .WIDTH(16), .NFRAC(10), .INPUT_SIZE(16), .OUTPUT_SIZE(5),
    .CAPTURE_DELAY(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .nn_input_ready(nn_input_ready), .nn_input_data(nn_input_data),
    .nn_output_ready(nn_output_ready), .nn_output_data(nn_output_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_frame(err_frame), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (nn_input_ready === 1'b1) launches++;

  // Stimulus: n beats of (base+i)<<10, s_last on beat last_at; counts err_frame beats.
  task automatic send_frame(input int n, input int last_at, input int base, output int nerr);
    nerr = 0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 16'((base + i) << 10);
      s_last  = (i == last_at);
      #1;
      if (err_frame === 1'b1) nerr++;
      @(posedge clk); @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  function automatic logic [255:0] exp_vec(input int base);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'((base + i) << 10);
    return v;
  endfunction

  task automatic raise_result(input logic [15:0] v [5]);
    for (int i = 0; i < 5; i++) nn_output_data[i*16 +: 16] = v[i];
    nn_output_ready = 1'b1;
  endtask

  // Collects outbound words; optional 1-0-0-1 m_ready pattern; counts data changes under stall.
  task automatic drain(input bit bp, output logic [15:0] w [8], output logic l [8],
                       output int n, output int unstable);
    bit pat [4];
    bit stalled;
    bit done;
    logic [15:0] held;
    int k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin w[i] = '0; l[i] = 1'b0; end
    n = 0; unstable = 0; stalled = 0; done = 0; held = '0; k = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (m_valid === 1'b1) begin
        m_ready = bp ? pat[k % 4] : 1'b1;
        k++;
        #1;
        if (stalled && (m_data !== held)) unstable++;
        if (m_ready) begin
          if (n < 8) begin w[n] = m_data; l[n] = m_last; end
          n++;
          stalled = 0;
          if (m_last === 1'b1) done = 1;
        end else begin
          stalled = 1;
          held = m_data;
        end
      end else begin
        m_ready = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    vecs++; if (nn_input_ready !== 1'b0) begin errs++; $display("FAIL rst_launch: got %b want 0", nn_input_ready); end
    vecs++; if (nn_input_data !== '0) begin errs++; $display("FAIL rst_in_data: got %h want 0", nn_input_data); end
    vecs++; if ({m_data, m_last, err_frame, err_timeout} !== 19'd0) begin errs++;
      $display("FAIL rst_misc: got %h/%b/%b/%b want 0", m_data, m_last, err_frame, err_timeout); end
    reset = 1'b0;
    @(negedge clk);
    vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_nominal;
    logic [15:0] w [8];
    logic l [8];
    logic [15:0] r [5];
    logic [15:0] ex [6];
    int nerr, n, uns, l0;
    l0 = launches;
    ex = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd4};
    send_frame(16, 15, 0, nerr);
    vecs++; if (nerr != 0) begin errs++; $display("FAIL nom_err_frame: got %0d want 0", nerr); end
    vecs++; if (nn_input_ready !== 1'b1) begin errs++; $display("FAIL nom_launch: got %b want 1", nn_input_ready); end
    vecs++; if (nn_input_data !== exp_vec(0)) begin errs++; $display("FAIL nom_in_data: got %h want %h", nn_input_data, exp_vec(0)); end
    vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL nom_s_ready_launch: got %b want 0", s_ready); end
    @(negedge clk);
    vecs++; if (nn_input_ready !== 1'b0) begin errs++; $display("FAIL nom_launch_width: got %b want 0", nn_input_ready); end
    repeat (4) @(negedge clk);
    r = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
    raise_result(r);
    @(negedge clk);
    vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL nom_early_valid: got %b want 0", m_valid); end
    @(negedge clk);
    vecs++; if (m_valid !== 1'b1) begin errs++; $display("FAIL nom_latency: got %b want 1", m_valid); end
    drain(1'b0, w, l, n, uns);
    nn_output_ready = 1'b0;
    vecs++; if (n != NW) begin errs++; $display("FAIL nom_count: got %0d want %0d", n, NW); end
    for (int k = 0; k < NW; k++) begin
      vecs++; if (w[k] !== ex[k] || l[k] !== (k == NW - 1)) begin errs++;
        $display("FAIL nom_word%0d: got %0d last %b want %0d last %b", k, w[k], l[k], ex[k], (k == NW - 1)); end
    end
    vecs++; if (launches - l0 != 1) begin errs++; $display("FAIL nom_launch_count: got %0d want 1", launches - l0); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL nom_idle: got %b want 0", busy); end
    vecs++; if (nn_input_data !== exp_vec(0)) begin errs++; $display("FAIL nom_in_hold: got %h", nn_input_data); end
  endtask

  task automatic test_backpressure;
    logic [15:0] w [8];
    logic l [8];
    logic [15:0] r [5];
    logic [15:0] ex [6];
    int nerr, n, uns;
    ex = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd55, 16'd4};
    send_frame(16, 15, 4, nerr);
    @(negedge clk);
    r = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd55};
    raise_result(r);
    drain(1'b1, w, l, n, uns);
    nn_output_ready = 1'b0;
    vecs++; if (n != NW) begin errs++; $display("FAIL bp_count: got %0d want %0d", n, NW); end
    vecs++; if (uns != 0) begin errs++; $display("FAIL bp_stable: got %0d changes want 0", uns); end
    for (int k = 0; k < NW; k++) begin
      vecs++; if (w[k] !== ex[k] || l[k] !== (k == NW - 1)) begin errs++;
        $display("FAIL bp_word%0d: got %0d last %b want %0d", k, w[k], l[k], ex[k]); end
    end
  endtask

  task automatic test_early_last;
    logic [15:0] w [8];
    logic l [8];
    logic [15:0] r [5];
    int nerr, n, uns, l0;
    l0 = launches;
    send_frame(8, 7, 0, nerr);
    vecs++; if (nerr != 1) begin errs++; $display("FAIL early_err_frame: got %0d want 1", nerr); end
    vecs++; if (busy !== 1'b0 || s_ready !== 1'b1) begin errs++; $display("FAIL early_stay_fill: busy %b s_ready %b", busy, s_ready); end
    repeat (2) @(negedge clk);
    vecs++; if (launches != l0) begin errs++; $display("FAIL early_no_launch: got %0d want 0", launches - l0); end
    send_frame(16, 15, 32, nerr);
    vecs++; if (nerr != 0) begin errs++; $display("FAIL early_next_err: got %0d want 0", nerr); end
    vecs++; if (nn_input_ready !== 1'b1) begin errs++; $display("FAIL early_next_launch: got %b want 1", nn_input_ready); end
    vecs++; if (nn_input_data !== exp_vec(32)) begin errs++; $display("FAIL early_next_data: got %h want %h", nn_input_data, exp_vec(32)); end
    @(negedge clk);
    r = '{16'd7, 16'd8, 16'd9, 16'd10, 16'd11};
    raise_result(r);
    drain(1'b0, w, l, n, uns);
    nn_output_ready = 1'b0;
    vecs++; if (n != NW || w[0] !== 16'd7) begin errs++; $display("FAIL early_drain: got %0d words first %0d want %0d first 7", n, w[0], NW); end
  endtask

  task automatic test_stale_ready;
    logic [15:0] w [8];
    logic l [8];
    logic [15:0] r [5];
    int nerr, n, uns;
    r = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    raise_result(r);
    send_frame(16, 15, 1, nerr);
    vecs++; if (nn_input_ready !== 1'b1) begin errs++; $display("FAIL stale_launch: got %b want 1", nn_input_ready); end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      vecs++; if (m_valid !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL stale_hold%0d: m_valid %b busy %b want 0/1", k, m_valid, busy); end
    end
    nn_output_ready = 1'b0;
    @(negedge clk);
    r = '{16'd21, 16'd22, 16'd23, 16'd24, 16'd25};
    raise_result(r);
    @(negedge clk);
    vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL stale_early: got %b want 0", m_valid); end
    @(negedge clk);
    vecs++; if (m_valid !== 1'b1) begin errs++; $display("FAIL stale_latency: got %b want 1", m_valid); end
    drain(1'b0, w, l, n, uns);
    nn_output_ready = 1'b0;
    vecs++; if (n != NW || w[0] !== 16'd21 || w[4] !== 16'd25) begin errs++;
      $display("FAIL stale_data: got %0d words %0d..%0d want %0d words 21..25", n, w[0], w[4], NW); end
  endtask

  task automatic test_timeout;
    int nerr;
    nn_output_ready = 1'b0;
    send_frame(16, 15, 2, nerr);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vecs++; if (err_timeout !== (k == 8)) begin errs++; $display("FAIL to_pulse_c%0d: got %b want %b", k, err_timeout, (k == 8)); end
    end
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0 || err_timeout !== 1'b0) begin errs++;
      $display("FAIL to_return: busy %b s_ready %b m_valid %b err %b want 0/1/0/0", busy, s_ready, m_valid, err_timeout); end
  endtask

  task automatic test_reset_mid_drain;
    logic [15:0] r [5];
    int nerr;
    send_frame(16, 15, 3, nerr);
    @(negedge clk);
    r = '{16'd31, 16'd32, 16'd33, 16'd34, 16'd35};
    raise_result(r);
    repeat (2) @(negedge clk);
    vecs++; if (m_valid !== 1'b1) begin errs++; $display("FAIL rmd_valid: got %b want 1", m_valid); end
    m_ready = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    m_ready = 1'b0;
    vecs++; if (m_data !== 16'd33) begin errs++; $display("FAIL rmd_third_word: got %0d want 33", m_data); end
    #2 reset = 1'b1;
    #1;
    vecs++; if (m_valid !== 1'b0 || m_data !== 16'd0 || m_last !== 1'b0) begin errs++;
      $display("FAIL rmd_async_out: m_valid %b m_data %0d m_last %b want 0", m_valid, m_data, m_last); end
    vecs++; if (s_ready !== 1'b1 || busy !== 1'b0 || nn_input_data !== '0) begin errs++;
      $display("FAIL rmd_async_state: s_ready %b busy %b in_data %h", s_ready, busy, nn_input_data); end
    nn_output_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rmd_after: m_valid %b busy %b want 0", m_valid, busy); end
  endtask

`ifdef MLP_ADAPTER_ARGMAX_EN
  task automatic test_argmax;
    logic [15:0] w [8];
    logic l [8];
    logic [15:0] r [5];
    int nerr, n, uns;
    send_frame(16, 15, 5, nerr);
    @(negedge clk);
    r = '{16'hFFFB, 16'd700, 16'd700, 16'd3, 16'd0};
    raise_result(r);
    drain(1'b0, w, l, n, uns);
    nn_output_ready = 1'b0;
    vecs++; if (n != 6) begin errs++; $display("FAIL amax_count: got %0d want 6", n); end
    vecs++; if (w[5] !== 16'd1 || l[5] !== 1'b1) begin errs++; $display("FAIL amax_word: got %0d last %b want 1 last 1", w[5], l[5]); end
    vecs++; if (l[4] !== 1'b0 || w[0] !== 16'hFFFB) begin errs++; $display("FAIL amax_body: last4 %b w0 %h want 0 fffb", l[4], w[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_last();
    test_stale_ready();
    test_timeout();
    test_reset_mid_drain();
`ifdef MLP_ADAPTER_ARGMAX_EN
    test_argmax();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mlp_stream_adapter.md
Name: mlp_stream_adapter

Overview:
- Stream front/back end for the jet-tagging MLP top level.
- Collects INPUT_SIZE feature words from a valid/ready stream into a vector, then presents it to the network with a one-cycle input_ready pulse.
- Waits for the network's output_ready, captures the OUTPUT_SIZE result vector, and serialises it onto an outbound valid/ready stream.
- Replaces ad-hoc testbench drivers and lets the network sit behind a word-serial host interface.

Parameters:
- WIDTH, 16, fixed-point word width (signed)
- NFRAC, 10, fractional bits; pass-through only, no arithmetic depends on it
- INPUT_SIZE, 16, feature words per frame
- OUTPUT_SIZE, 5, result words per frame
- CAPTURE_DELAY, 1, cycles between the output_ready rising edge and result capture; covers softmax register latency
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before abort

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  inbound word valid
- s_ready  out  1  adapter accepts inbound word
- s_data  in  WIDTH  inbound feature word, signed
- s_last  in  1  marks last word of inbound frame
- nn_input_ready  out  1  one-cycle launch pulse to network
- nn_input_data  out  WIDTH x INPUT_SIZE  feature vector to network
- nn_output_ready  in  1  network result-ready level
- nn_output_data  in  WIDTH x OUTPUT_SIZE  network result vector
- m_valid  out  1  outbound word valid
- m_ready  in  1  downstream accepts word
- m_data  out  WIDTH  outbound result word
- m_last  out  1  last word of outbound frame
- busy  out  1  high in any state other than FILL
- err_frame  out  1  one-cycle pulse on framing error
- err_timeout  out  1  one-cycle pulse on network timeout

Behaviour:
- Reset values (asynchronous):
  - State = FILL; word indices = 0; input buffer = 0; result buffer = 0.
  - All outputs = 0 except s_ready, which is 1 because it decodes from the FILL state.
- State machine: FILL -> LAUNCH -> WAIT -> (DLY) -> DRAIN -> FILL.
- FILL:
  - s_ready=1; s_valid&&s_ready is a beat; the beat writes buf[idx] and then increments idx.
  - Beat with idx==INPUT_SIZE-1 goes to LAUNCH and resets idx to 0.
  - If that final beat has s_last=0: pulse err_frame; the frame is still launched.
  - s_last=1 on a beat with idx<INPUT_SIZE-1: pulse err_frame, discard the frame, set idx=0, stay in FILL. Buffer contents are not cleared.
- LAUNCH (1 cycle):
  - nn_input_ready=1.
  - nn_input_data is driven from registers and stays stable from LAUNCH until the next FILL completes.
  - Record the current nn_output_ready as prev; go to WAIT.
- WAIT:
  - Wait for a rising edge of nn_output_ready (current=1, prev=0; prev updates every cycle).
  - A level left high from a previous inference must not trigger capture.
  - On the edge with CAPTURE_DELAY=0: capture nn_output_data this cycle and go to DRAIN.
  - On the edge with CAPTURE_DELAY>0: go to DLY, count CAPTURE_DELAY cycles, capture, then go to DRAIN.
  - A timeout counter starts at 0 on entry. At TIMEOUT_CYCLES-1 with no edge: pulse err_timeout, go to FILL, and discard the result.
- DRAIN:
  - m_valid=1, m_data=obuf[oidx], m_last=(oidx==OUTPUT_SIZE-1).
  - oidx advances only on m_valid&&m_ready.
  - The last beat goes to FILL.
  - m_data and m_last hold stable while m_valid=1 && m_ready=0 (AXI-stream rule).
- s_ready=0 outside FILL; there is no overlap of frames.
- Inbound latency: the last input beat at cycle t gives nn_input_ready at t+1.
- Outbound latency: the output_ready edge at cycle t gives the first m_valid at t+1+CAPTURE_DELAY.
- Reset asserted mid-operation aborts immediately to reset values; no partial output completes.
- Data is transferred bit-exact; no saturation or rounding.

Optional Feature:
- Macro: MLP_ADAPTER_ARGMAX_EN.
- Defined:
  - DRAIN emits OUTPUT_SIZE+1 words; the extra final word is the zero-extended index of the largest signed result.
  - Ties resolve to the lowest index.
  - m_last moves to the index word.
  - The argmax is computed at capture and registered.
- Undefined: exactly OUTPUT_SIZE words are emitted; no argmax logic is present.

Decomposition:
- Package mlp_adapter_pkg holds:
  - state enum (FILL, LAUNCH, WAIT, DLY, DRAIN);
  - localparams IDX_W=$clog2(INPUT_SIZE), OIDX_W=$clog2(OUTPUT_SIZE+1), TO_W=$clog2(TIMEOUT_CYCLES).
- One sub-module, mlp_argmax:
  - combinational, parameters WIDTH and N;
  - instantiated only under MLP_ADAPTER_ARGMAX_EN.

Test Plan:
- Nominal frame:
  - Stimulus: 16 beats, values 0..15 (<<NFRAC), s_last on beat 15; model asserts output_ready 5 cycles after the launch pulse with outputs {100,200,300,400,500}.
  - Response: exactly one nn_input_ready pulse; nn_input_data[i]=i<<10; m_data sequence 100..500; m_last on 500.
- Backpressure:
  - Stimulus: m_ready toggles 1-0-0-1 during DRAIN.
  - Response: no dropped or duplicated words; m_data stable while stalled.
- Early s_last:
  - Stimulus: s_last on beat 7.
  - Response: err_frame pulses once; no launch; the next 16-beat frame launches with correct data.
- Stale output_ready:
  - Stimulus: nn_output_ready held high across LAUNCH.
  - Response: no capture until it falls and rises again.
- Timeout, then reset mid-DRAIN:
  - Stimulus: TIMEOUT_CYCLES=8 with output_ready never asserted; then reset asserted after 2 output beats.
  - Response: err_timeout pulses at WAIT cycle 8 and state returns to FILL; on reset, outputs go to reset values asynchronously and s_ready=1.
- With MLP_ADAPTER_ARGMAX_EN:
  - Stimulus: outputs {-5,700,700,3,0}.
  - Response: 6 words, final word = 1, m_last on it.
